// File: rtl/reg_write_demux_32.sv
// Write side of the 32-word register file: handshaked single-word writes plus a
// one-register-per-cycle clear sweep; all words are exposed on a flat bus.
module reg_write_demux_32 #(
  parameter int DATA_W    = 32,
  parameter bit ZERO_REG0 = 1'b1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [4:0]           wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  output logic                 wr_done,
  input  logic                 clr_req,
  output logic                 busy,
  output logic [32*DATA_W-1:0] regs_out,
  output logic                 dbg_state
);

  // Handshake: a write is taken at a rising edge where wr_valid && wr_ready;
  // wr_ready depends on state only, so the sender may wait on it freely.
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [4:0]          clr_cnt_q, clr_cnt_d;
  logic                wr_done_q, wr_done_d;
  logic [DATA_W-1:0]   regs_q [32];
  logic [DATA_W-1:0]   regs_d [32];
  logic                wr_accept;
  logic [31:0]         wr_sel;
  logic [31:0]         clr_hit;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wr_accept = wr_valid && (state_q == IDLE);
    wr_done_d = wr_accept;
    wr_sel    = '0;
    clr_hit   = '0;
    case (state_q)
      IDLE: begin
        if (wr_accept) wr_sel = 32'd1 << wr_addr;
        if (clr_req) begin
          state_d   = CLEAR;
          clr_cnt_d = 5'd0;
        end
      end
      CLEAR: begin
        clr_hit   = 32'd1 << clr_cnt_q;
        clr_cnt_d = clr_cnt_q + 5'd1;
        if (clr_cnt_q == 5'd31) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Hardwired word 0 never loads, so its flop stays at its reset value.
    if (ZERO_REG0) wr_sel[0] = 1'b0;
    for (int k = 0; k < 32; k++) begin
      regs_d[k] = regs_q[k];
      if (clr_hit[k])     regs_d[k] = '0;
      else if (wr_sel[k]) regs_d[k] = wr_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      clr_cnt_q <= 5'd0;
      wr_done_q <= 1'b0;
      for (int k = 0; k < 32; k++) regs_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      wr_done_q <= wr_done_d;
      for (int k = 0; k < 32; k++) regs_q[k] <= regs_d[k];
    end
  end

  for (genvar k = 0; k < 32; k++) begin : g_out
    assign regs_out[k*DATA_W +: DATA_W] = (k == 0 && ZERO_REG0) ? '0 : regs_q[k];
  end

  assign wr_ready  = (state_q == IDLE);
  assign busy      = (state_q == CLEAR);
  assign wr_done   = wr_done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_write_demux_32.sv
// Directed bench for reg_write_demux_32: writes, hardwired word 0, clear sweep,
// write/clear collision and reset during a sweep.
module tb_reg_write_demux_32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          wr_valid;
  logic          wr_ready;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          wr_done;
  logic          clr_req;
  logic          busy;
  logic [1023:0] regs_out;
  logic          dbg_state;

  int            n_total = 0;
  int            n_bad   = 0;
  logic [31:0]   exp_regs [32];
  logic [31:0]   exp_q [$];

  reg_write_demux_32 #(.DATA_W(32), .ZERO_REG0(1'b1)) dut (
    .clock     (clk),
    .resetn    (resetn),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_done   (wr_done),
    .clr_req   (clr_req),
    .busy      (busy),
    .regs_out  (regs_out),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int k);
    return regs_out[k*32 +: 32];
  endfunction

  task automatic check_words(input string tag);
    for (int k = 0; k < 32; k++)
      check($sformatf("%s_w%0d", tag, k), word(k), exp_regs[k]);
  endtask

  task automatic clear_model();
    for (int k = 0; k < 32; k++) exp_regs[k] = 32'h0;
  endtask

  // driver tasks: inputs change on the falling edge, outputs are checked there too
  task automatic idle_inputs();
    wr_valid = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 32'h0;
    clr_req  = 1'b0;
  endtask

  task automatic drive_write(input logic [4:0] a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, {31'b0, wr_ready}, 32'd1);
    check({tag, "_busy"},  {31'b0, busy},     32'd0);
    check({tag, "_done"},  {31'b0, wr_done},  32'd0);
    check({tag, "_state"}, {31'b0, dbg_state}, 32'd0);
  endtask

  initial begin
    logic [31:0] e;
    idle_inputs();
    clear_model();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    check_words("rst_hold");
    resetn = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_rel");

    // back-to-back writes to 5 and 31
    drive_write(5'd5, 32'hDEADBEEF);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    e = exp_q.pop_front();
    check("b2b_done0", {31'b0, wr_done}, 32'd1);
    check("b2b_w5", word(5), e);
    drive_write(5'd31, 32'h12345678);
    exp_q.push_back(32'h12345678);
    @(negedge clk);
    e = exp_q.pop_front();
    check("b2b_done1", {31'b0, wr_done}, 32'd1);
    check("b2b_w31", word(31), e);
    idle_inputs();
    @(negedge clk);
    check("b2b_done_end", {31'b0, wr_done}, 32'd0);
    exp_regs[5]  = 32'hDEADBEEF;
    exp_regs[31] = 32'h12345678;
    check_words("b2b");

    // same address on consecutive cycles keeps the last value
    drive_write(5'd9, 32'h11111111);
    @(negedge clk);
    drive_write(5'd9, 32'h22222222);
    @(negedge clk);
    idle_inputs();
    check("same_addr_w9", word(9), 32'h22222222);
    exp_regs[9] = 32'h22222222;

    // word 0 is hardwired to zero
    drive_write(5'd0, 32'hFFFFFFFF);
    @(negedge clk);
    idle_inputs();
    check("zero_done", {31'b0, wr_done}, 32'd1);
    check("zero_w0", word(0), 32'h0);
    @(negedge clk);
    check("zero_w0_later", word(0), 32'h0);
    check_words("zero");

    // asynchronous reset in the middle of traffic
    drive_write(5'd12, 32'h0F0F0F0F);
    @(negedge clk);
    drive_write(5'd13, 32'h3C3C3C3C);
    #2;
    resetn = 1'b0;
    #1;
    clear_model();
    check_words("mid_rst");
    check("mid_rst_done", {31'b0, wr_done}, 32'd0);
    idle_inputs();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_idle_outputs("mid_rst_rel");
    check_words("mid_rst_rel");

    // load every word with k+1, then sweep
    for (int k = 0; k < 32; k++) begin
      drive_write(5'(k), 32'(k + 1));
      @(negedge clk);
      exp_regs[k] = (k == 0) ? 32'h0 : 32'(k + 1);
    end
    idle_inputs();
    check_words("load");
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    for (int j = 0; j <= 32; j++) begin
      if (j > 0) exp_regs[j-1] = 32'h0;
      check($sformatf("sweep_busy_c%0d", j),  {31'b0, busy},     (j < 32) ? 32'd1 : 32'd0);
      check($sformatf("sweep_ready_c%0d", j), {31'b0, wr_ready}, (j < 32) ? 32'd0 : 32'd1);
      check_words($sformatf("sweep_c%0d", j));
      @(negedge clk);
    end
    check_idle_outputs("sweep_end");

    // write and clear in the same cycle; a held write waits for wr_ready
    drive_write(5'd7, 32'hA5A5A5A5);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    check("coll_done", {31'b0, wr_done}, 32'd1);
    check("coll_busy", {31'b0, busy}, 32'd1);
    check("coll_w7_c0", word(7), 32'hA5A5A5A5);
    drive_write(5'd12, 32'h0BADF00D);
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      check($sformatf("coll_w7_c%0d", j), word(7), (j < 8) ? 32'hA5A5A5A5 : 32'h0);
      check($sformatf("coll_w12_c%0d", j), word(12), 32'h0);
      check($sformatf("coll_done_c%0d", j), {31'b0, wr_done}, 32'd0);
    end
    check("coll_ready_back", {31'b0, wr_ready}, 32'd1);
    @(negedge clk);
    idle_inputs();
    check("coll_late_done", {31'b0, wr_done}, 32'd1);
    check("coll_late_w12", word(12), 32'h0BADF00D);
    @(negedge clk);
    check("coll_late_done_end", {31'b0, wr_done}, 32'd0);

    // reset pulse at sweep cycle 10
    drive_write(5'd20, 32'h00000055);
    @(negedge clk);
    idle_inputs();
    check("pre_sweep_w20", word(20), 32'h00000055);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    check("sweep10_busy", {31'b0, busy}, 32'd1);
    check("sweep10_w20", word(20), 32'h00000055);
    resetn = 1'b0;
    #1;
    clear_model();
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_ready", {31'b0, wr_ready}, 32'd1);
    check_words("abort");
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check_idle_outputs("abort_rel");
    drive_write(5'd3, 32'hCAFEF00D);
    @(negedge clk);
    idle_inputs();
    exp_regs[3] = 32'hCAFEF00D;
    check("post_abort_done", {31'b0, wr_done}, 32'd1);
    check_words("post_abort");
    @(negedge clk);
    check("post_abort_busy", {31'b0, busy}, 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
